// File: rtl/compare.sv
// Unsigned WIDTH-bit comparator of x against reference key crux, with a registered match
// flag, a match rising-edge pulse and a saturating match counter.
module compare #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] crux,
    output logic             result,
    output logic             gt,
    output logic             lt,
    output logic             result_q,
    output logic             match_rise,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic             result_d;
    logic             match_rise_d;
    logic             match_rise_q;
    logic [CNT_W-1:0] match_cnt_d;
    logic [CNT_W-1:0] match_cnt_q;

    // lt is derived from the other two so exactly one flag is ever high.
    always_comb begin
        result = (x == crux);
        gt     = (x > crux);
        lt     = ~result & ~gt;
    end

    always_comb begin
        result_d     = result;
        match_rise_d = result & ~result_q;
        match_cnt_d  = match_cnt_q;
        if (result && (match_cnt_q != CntMax)) begin
            match_cnt_d = match_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q     <= 1'b0;
            match_rise_q <= 1'b0;
            match_cnt_q  <= '0;
        end else begin
            result_q     <= result_d;
            match_rise_q <= match_rise_d;
            match_cnt_q  <= match_cnt_d;
        end
    end

    assign match_rise = match_rise_q;
    assign match_cnt  = match_cnt_q;

endmodule

// File: tb/tb_compare.sv
// Directed bench for compare: a default instance and a CNT_W=2 instance share stimulus and
// are checked every cycle against a behavioural model, plus literal expectations.
module tb_compare;

    logic       clk;
    logic       rst;
    logic [2:0] x;
    logic [2:0] crux;

    logic       result, gt, lt, result_q, match_rise;
    logic [7:0] match_cnt;
    logic       result_s, gt_s, lt_s, result_q_s, match_rise_s;
    logic [1:0] match_cnt_s;

    int n_chk  = 0;
    int n_fail = 0;

    compare #(.WIDTH(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .x(x), .crux(crux),
        .result(result), .gt(gt), .lt(lt),
        .result_q(result_q), .match_rise(match_rise), .match_cnt(match_cnt)
    );

    compare #(.WIDTH(3), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .x(x), .crux(crux),
        .result(result_s), .gt(gt_s), .lt(lt_s),
        .result_q(result_q_s), .match_rise(match_rise_s), .match_cnt(match_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: history of sampled matches at each posedge.
    bit m_valid = 0;
    bit m_q, m_rise;
    int m_cnt, m_cnt_s;

    always @(posedge clk) begin
        bit eq;
        eq = (int'(x) == int'(crux));
        if (rst) begin
            m_q = 0; m_rise = 0; m_cnt = 0; m_cnt_s = 0; m_valid = 1;
        end else begin
            m_rise = eq && !m_q;
            m_q    = eq;
            if (eq) begin
                m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_cnt_s = (m_cnt_s < 3) ? m_cnt_s + 1 : 3;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("result",       32'(result),     32'(int'(x) == int'(crux)));
            chk("gt",           32'(gt),         32'(int'(x) > int'(crux)));
            chk("lt",           32'(lt),         32'(int'(x) < int'(crux)));
            chk("one_hot",      32'(int'(result) + int'(gt) + int'(lt)), 32'd1);
            chk("result_q",     32'(result_q),   32'(m_q));
            chk("match_rise",   32'(match_rise), 32'(m_rise));
            chk("match_cnt",    32'(match_cnt),  32'(m_cnt));
            chk("result_q_s",   32'(result_q_s), 32'(m_q));
            chk("match_rise_s", 32'(match_rise_s), 32'(m_rise));
            chk("match_cnt_s",  32'(match_cnt_s), 32'(m_cnt_s));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lt_tbl;
        logic [7:0] gt_tbl;
        lt_tbl = 8'b0000_0111;
        gt_tbl = 8'b1111_0000;

        rst = 1'b1; x = 3'd0; crux = 3'd3;
        cycle(); cycle();

        // Sweep x against key 3.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            x = 3'(i);
            #1;
            chk("sweep_result", 32'(result), 32'(i == 3));
            chk("sweep_lt",     32'(lt),     32'(lt_tbl[i]));
            chk("sweep_gt",     32'(gt),     32'(gt_tbl[i]));
            cycle();
        end

        // Reset held with a match present, then released.
        x = 3'd3; crux = 3'd3; rst = 1'b1;
        cycle(); cycle();
        chk("rst_result_q",   32'(result_q),   32'd0);
        chk("rst_match_rise", 32'(match_rise), 32'd0);
        chk("rst_match_cnt",  32'(match_cnt),  32'd0);
        rst = 1'b0;
        cycle();
        chk("rel_result_q",   32'(result_q),   32'd1);
        chk("rel_match_rise", 32'(match_rise), 32'd1);
        cycle();
        chk("rel_rise_drop",  32'(match_rise), 32'd0);
        cycle(); cycle(); cycle();
        chk("hold5_cnt",      32'(match_cnt),  32'd5);
        chk("hold5_cnt_s",    32'(match_cnt_s), 32'd3);
        cycle();
        chk("hold6_cnt",      32'(match_cnt),  32'd6);
        chk("sat_cnt_s",      32'(match_cnt_s), 32'd3);

        // Alternating match / mismatch.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        x = 3'd3; cycle();
        x = 3'd5; cycle();
        chk("alt_rise_low",   32'(match_rise), 32'd0);
        x = 3'd3; cycle();
        chk("alt_rise2",      32'(match_rise), 32'd1);
        x = 3'd5; cycle();
        x = 3'd3; cycle();
        chk("alt_rise3",      32'(match_rise), 32'd1);
        chk("alt_cnt",        32'(match_cnt),  32'd3);

        // Reset mid-count.
        cycle();
        chk("mid_cnt4",       32'(match_cnt),  32'd4);
        rst = 1'b1;
        cycle();
        chk("mid_result",     32'(result),     32'd1);
        chk("mid_result_q",   32'(result_q),   32'd0);
        chk("mid_rise",       32'(match_rise), 32'd0);
        chk("mid_cnt",        32'(match_cnt),  32'd0);
        rst = 1'b0;
        cycle();
        chk("mid_rel_rise",   32'(match_rise), 32'd1);
        chk("mid_rel_cnt",    32'(match_cnt),  32'd1);

        // Other keys and extremes.
        crux = 3'd7; x = 3'd7; #1;
        chk("k7_eq", 32'(result), 32'd1);
        cycle();
        x = 3'd0; #1;
        chk("k7_lt", 32'(lt), 32'd1);
        cycle();
        crux = 3'd0; #1;
        chk("k0_eq", 32'(result), 32'd1);
        cycle();
        x = 3'd5; crux = 3'd2; #1;
        chk("k2_gt", 32'(gt), 32'd1);
        cycle();
        x = 3'd2; crux = 3'd5; #1;
        chk("k5_lt", 32'(lt), 32'd1);
        cycle(); cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
